// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arbiter
//  Description : Round-robin sharing of one up-counting timer between
//                NUM_REQ requesters. The winner's duration is latched, the
//                count runs 0..dur-1, then a one-cycle done pulse goes back
//                to the winner. A zero duration is treated as one cycle.
//                Optional build macro TIMER_ARB_ABORT_EN: when defined, the
//                owner dropping its request mid-run cancels the job without
//                a done pulse.
//                ID_W must equal clog2(NUM_REQ).
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIME_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*TIME_W-1:0] dur_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [ID_W-1:0]           owner_o,
  output logic                      busy_o,
  output logic [TIME_W-1:0]         curr_time_q,
  output logic [NUM_REQ-1:0]        done_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q,  last_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q,  done_d;
  logic [TIME_W-1:0]   dur_q,   dur_d;
  logic [TIME_W-1:0]   time_d;

  // Arbitration results
  logic [NUM_REQ-1:0]  elig;
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  int                  scan;
  logic [TIME_W-1:0]   win_dur;
  logic [TIME_W-1:0]   win_dur_eff;

  // Job completion / abort decode
  logic                last_tick;
  logic                abort_req;

  // Per-requester view of the packed duration bus
  logic [TIME_W-1:0]   dur_arr [NUM_REQ];

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign dur_arr[k] = dur_i[k*TIME_W +: TIME_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin winner: first eligible requester after last_q, wrapping.
  // A requester pulsing done this cycle is masked so it cannot be re-granted
  // before it has had a chance to drop its request.
  // --------------------------------------------------------------------------
  always_comb begin
    elig      = req_i & ~done_q;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan = int'(last_q) + i;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      if (!win_found && elig[scan]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(scan);
      end
    end
  end

  // Duration of the winner; zero is promoted to one so the job always lasts
  // at least a single RUN cycle and the terminal-count compare never wraps.
  always_comb begin
    win_dur     = dur_arr[win_idx];
    win_dur_eff = (win_dur == '0) ? TIME_W'(1) : win_dur;
  end

  // Terminal count and (optional) owner-abort decode while running
  always_comb begin
    last_tick = (curr_time_q == (dur_q - TIME_W'(1)));
`ifdef TIMER_ARB_ABORT_EN
    abort_req = ~req_i[owner_q];
`else
    abort_req = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    dur_d   = dur_q;
    time_d  = curr_time_q;
    done_d  = '0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        owner_d = '0;
        time_d  = '0;
        if (win_found) begin
          state_d = RUN;
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          dur_d   = win_dur_eff;
        end
      end

      RUN: begin
        if (abort_req) begin
          // Cancelled job: back to idle silently, pointer keeps the owner
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
          time_d  = '0;
        end else if (last_tick) begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
          time_d  = '0;
          done_d  = grant_q;
        end else begin
          time_d  = curr_time_q + TIME_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        time_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= LAST_RESET;
      owner_q     <= '0;
      grant_q     <= '0;
      dur_q       <= TIME_W'(1);
      curr_time_q <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      dur_q       <= dur_d;
      curr_time_q <= time_d;
      done_q      <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_arbiter
//  Description : Self-checking bench for timer_arbiter: directed vector
//                table, hand-written multi-cycle sequences and randomized
//                traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIME_W  = 16;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TIME_W-1:0] dur;
  logic [NUM_REQ-1:0]        grant_o;
  logic [ID_W-1:0]           owner_o;
  logic                      busy_o;
  logic [TIME_W-1:0]         curr_time_q;
  logic [NUM_REQ-1:0]        done_o;

  int n_checks = 0;
  int n_fail   = 0;

  timer_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIME_W  (TIME_W),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .dur_i       (dur),
    .grant_o     (grant_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .curr_time_q (curr_time_q),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [63:0] D(input int d0, input int d1, input int d2, input int d3);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [63:0] du);
    rst = r;
    req = rq;
    dur = du;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference model (one call per clock edge)
  // --------------------------------------------------------------------------
  int          m_busy, m_owner, m_t, m_dur, m_last;
  logic [3:0]  m_done;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [63:0] du);
    logic [3:0] elig;
    int         w;
    int         d;
    if (r) begin
      m_busy = 0; m_owner = 0; m_t = 0; m_done = 4'b0; m_last = NUM_REQ - 1;
    end else if (m_busy == 0) begin
      elig   = rq & ~m_done;
      m_done = 4'b0;
      w = -1;
      for (int j = 1; j <= NUM_REQ; j++) begin
        if (w < 0 && elig[(m_last + j) % NUM_REQ]) w = (m_last + j) % NUM_REQ;
      end
      if (w >= 0) begin
        d       = int'(du[w*16 +: 16]);
        m_busy  = 1;
        m_owner = w;
        m_t     = 0;
        m_last  = w;
        m_dur   = (d == 0) ? 1 : d;
      end
    end else begin
      m_done = 4'b0;
`ifdef TIMER_ARB_ABORT_EN
      if (!rq[m_owner]) begin
        m_busy = 0; m_owner = 0; m_t = 0;
      end else
`endif
      if (m_t == m_dur - 1) begin
        m_done  = 4'(1 << m_owner);
        m_busy  = 0;
        m_owner = 0;
        m_t     = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table: inputs applied before an edge, outputs expected
  // just after it.
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] dur;
    logic [3:0]  eg;
    logic [1:0]  eo;
    logic        eb;
    logic [15:0] et;
    logic [3:0]  ed;
  } vec_t;

  vec_t vecs [13];

  logic [3:0]  req_r;
  logic [15:0] dur_r [4];
  logic [3:0]  prev_g, prev_d;
  int          order [$];
  int          starts [$];
  int          prev_t;
  bit          found;

  initial begin
    vecs[0]  = '{1'b1, 4'b1111, D(3,3,3,3), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0000};
    vecs[1]  = '{1'b1, 4'b1111, D(3,3,3,3), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0001, D(3,0,0,0), 4'b0001, 2'd0, 1'b1, 16'd0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0001, D(3,0,0,0), 4'b0001, 2'd0, 1'b1, 16'd1, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0001, D(3,0,0,0), 4'b0001, 2'd0, 1'b1, 16'd2, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0001, D(3,0,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0001};
    vecs[6]  = '{1'b0, 4'b0000, D(0,0,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0010, D(0,0,0,0), 4'b0010, 2'd1, 1'b1, 16'd0, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0010, D(0,7,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0010};
    vecs[9]  = '{1'b0, 4'b0010, D(0,0,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0000};
    vecs[10] = '{1'b0, 4'b0010, D(0,0,0,0), 4'b0010, 2'd1, 1'b1, 16'd0, 4'b0000};
    vecs[11] = '{1'b0, 4'b0010, D(0,0,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0010};
    vecs[12] = '{1'b0, 4'b0000, D(0,0,0,0), 4'b0000, 2'd0, 1'b0, 16'd0, 4'b0000};

    drive(1'b1, 4'b0, 64'd0);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].dur);
      step;
      check($sformatf("vec%0d_grant", i), 64'(grant_o),     64'(vecs[i].eg));
      check($sformatf("vec%0d_owner", i), 64'(owner_o),     64'(vecs[i].eo));
      check($sformatf("vec%0d_busy",  i), 64'(busy_o),      64'(vecs[i].eb));
      check($sformatf("vec%0d_time",  i), 64'(curr_time_q), 64'(vecs[i].et));
      check($sformatf("vec%0d_done",  i), 64'(done_o),      64'(vecs[i].ed));
    end

    // ---------------- Round-robin 0,2,0,2 with req 0101 held ----------------
    drive(1'b1, 4'b0, 64'd0);
    step;
    drive(1'b0, 4'b0101, D(2,0,2,0));
    prev_g = 4'b0;
    prev_d = 4'b0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      step;
      if (grant_o != 4'b0 && prev_g == 4'b0) begin
        order.push_back(int'(owner_o));
        starts.push_back(c);
        if (prev_d != 4'b0) check("rr_no_regrant", 64'(grant_o & prev_d), 64'd0);
      end
      prev_g = grant_o;
      prev_d = done_o;
    end
    check("rr_count", 64'(order.size()), 64'd4);
    if (order.size() == 4) begin
      check("rr_order0", 64'(order[0]), 64'd0);
      check("rr_order1", 64'(order[1]), 64'd2);
      check("rr_order2", 64'(order[2]), 64'd0);
      check("rr_order3", 64'(order[3]), 64'd2);
      for (int j = 1; j < 4; j++)
        check($sformatf("rr_spacing%0d", j), 64'(starts[j] - starts[j-1]), 64'd3);
    end

    // ---------------- Reset mid-run and pointer reset -----------------------
    drive(1'b1, 4'b0, 64'd0);
    step;
    drive(1'b0, 4'b1000, D(0,0,0,10));
    step;
    check("mr_grant3", 64'(grant_o), 64'b1000);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (curr_time_q == 16'd5) found = 1'b1;
      else step;
    end
    check("mr_reach5", 64'(found), 64'd1);
    drive(1'b1, 4'b1000, D(0,0,0,10));
    step;
    check("mr_outs_zero", 64'({grant_o, owner_o, busy_o, curr_time_q, done_o}), 64'd0);
    drive(1'b0, 4'b1001, D(3,0,0,10));
    step;
    check("mr_ptr_reset", 64'(grant_o), 64'b0001);
    check("mr_no_done", 64'(done_o), 64'd0);

    // ---------------- Owner drops request mid-run ---------------------------
    drive(1'b1, 4'b0, 64'd0);
    step;
    drive(1'b0, 4'b0010, D(0,10,0,0));
    step;
    check("ab_grant1", 64'(grant_o), 64'b0010);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (curr_time_q == 16'd2) found = 1'b1;
      else step;
    end
    check("ab_reach2", 64'(found), 64'd1);
    drive(1'b0, 4'b0000, D(0,10,0,0));
`ifdef TIMER_ARB_ABORT_EN
    step;
    check("ab_grant_off", 64'(grant_o), 64'd0);
    check("ab_busy_off",  64'(busy_o),  64'd0);
    check("ab_no_done",   64'(done_o),  64'd0);
    step;
    check("ab_no_done2",  64'(done_o),  64'd0);
`else
    step;
    check("ab_continues", 64'({busy_o, curr_time_q}), 64'({1'b1, 16'd3}));
    found  = 1'b0;
    prev_t = int'(curr_time_q);
    for (int c = 0; c < 20 && !found; c++) begin
      step;
      if (done_o != 4'b0) found = 1'b1;
      else prev_t = int'(curr_time_q);
    end
    check("ab_done_seen", 64'(found), 64'd1);
    check("ab_done_val",  64'(done_o), 64'b0010);
    check("ab_last_time", 64'(prev_t), 64'd9);
`endif

    // ---------------- Randomized traffic vs reference model -----------------
    req_r = 4'b0;
    for (int k = 0; k < 4; k++) dur_r[k] = 16'd0;
    drive(1'b1, 4'b0, 64'd0);
    model_step(1'b1, 4'b0, 64'd0);
    step;
    for (int it = 0; it < 3000; it++) begin
      check("rand_outputs",
            64'({grant_o, owner_o, busy_o, curr_time_q, done_o}),
            64'({(m_busy != 0) ? 4'(1 << m_owner) : 4'b0, 2'(m_owner),
                 1'(m_busy != 0), 16'(m_t), m_done}));
      for (int k = 0; k < 4; k++) begin
        if (req_r[k]) begin
          if (m_done[k] && ($urandom_range(0, 1) == 0)) req_r[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_r[k] = 1'b1;
        end
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 9) == 0) dur_r[k] = 16'($urandom_range(0, 40));
          else                           dur_r[k] = 16'($urandom_range(0, 6));
        end
      end
      drive(($urandom_range(0, 299) == 0), req_r,
            {dur_r[3], dur_r[2], dur_r[1], dur_r[0]});
      model_step(rst, req, dur);
      step;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one up-counting timer datapath between NUM_REQ requesters, each supplying its own duration.
- Round-robin arbitration. The winner's duration is latched, the count runs 0..dur-1, and a one-cycle done pulse is returned to the winner.
- Sits between the client blocks that need timed waits and the single counter resource, replacing per-client timer instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TIME_W, 16, width of durations and of the count.
- ID_W, 2, width of owner index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level; held until done or abort.
- dur_i  input  NUM_REQ*TIME_W  per-requester duration; slice k = bits [k*TIME_W +: TIME_W].
- grant_o  output  NUM_REQ  one-hot owner of the timer; all-zero when idle.
- owner_o  output  ID_W  index of current owner; 0 when idle.
- busy_o  output  1  high while in RUN.
- curr_time_q  output  TIME_W  running count of the current job; 0 when idle.
- done_o  output  NUM_REQ  one-cycle completion pulse to the finishing requester.

Behaviour:
- Reset (rst=1 at clk edge), taking effect next cycle, from any state including mid-run:
  - state=IDLE; grant_o=0, owner_o=0, busy_o=0, curr_time_q=0, done_o=0.
  - Round-robin pointer last_q=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, RUN.
- IDLE:
  - Eligible set = req_i with bit k masked when done_o[k]=1 in the same cycle. This prevents an instant re-grant before the owner drops req.
  - If eligible set nonzero: winner = first set bit scanning last_q+1, last_q+2, ... wrapping modulo NUM_REQ.
  - Next edge: state=RUN, grant_o=onehot(winner), owner_o=winner, busy_o=1, curr_time_q=0, last_q=winner.
  - Latch dur_q=dur_i[winner]; dur_i=0 is latched as 1.
  - Otherwise remain IDLE with outputs at idle values.
- RUN:
  - If curr_time_q == dur_q-1: next edge state=IDLE, grant_o=0, owner_o=0, busy_o=0, curr_time_q=0, done_o[owner]=1.
  - Otherwise curr_time_q increments by 1, everything else holds.
  - Latency: request sampled at edge E → grant visible E+1 → done visible E+1+dur → earliest next grant visible E+2+dur (one IDLE cycle between jobs).
- done_o:
  - Registered; high for exactly one cycle (the IDLE cycle following RUN), never in RUN.
  - At most one bit set.
- dur_i changes after grant are ignored (latched value used).
- Requests arriving during RUN wait; there is no preemption.
- Count width TIME_W, no overflow possible since dur_q ≤ 2^TIME_W-1.
- Max job length: 2^TIME_W-1 cycles in RUN.
- Simultaneous requests: exactly one granted per arbitration. With all NUM_REQ held continuously, grants go 0,1,2,3,0,...

Optional Feature:
- Macro TIMER_ARB_ABORT_EN.
- Defined: if req_i[owner]=0 while in RUN, next edge returns to IDLE with grant_o=0, busy_o=0, curr_time_q=0 and no done pulse. last_q still equals the aborted owner.
- Undefined: req_i is ignored while in RUN; the job always runs to completion and pulses done.

Test Plan:
- Reset: rst high 2 cycles with req_i=4'b1111 → grant_o=0, busy_o=0, curr_time_q=0, done_o=0 throughout; after release, requester 0 granted first.
- Single job: req_i=0001, dur_0=3, sampled at edge 0 → grant_o=0001 and busy_o=1 cycles 1-3, curr_time_q=0,1,2, done_o=0001 cycle 4, idle after if req dropped at cycle 4.
- Round-robin: req_i=0101 held continuously, dur_0=dur_2=2 → grant order 0,2,0,2. Each job is 2 RUN cycles plus 1 IDLE/done cycle, and the done owner is never re-granted in its done cycle.
- Zero duration: req_i=0010, dur_1=0 → grant_o=0010 for 1 cycle with curr_time_q=0, done_o=0010 next cycle.
- Reset mid-run: dur_3=10, assert rst at curr_time_q=5 → next cycle all outputs 0, no done pulse; with req_i=1001 after release, requester 0 wins (pointer reset).
- Abort: dur_1=10, drop req_1 at curr_time_q=2.
  - With TIMER_ARB_ABORT_EN: grant_o=0 next cycle and done_o stays 0.
  - Without it: run completes and done_o=0010 after curr_time_q=9.
